// File: rtl/pipe_stage_chain_if.sv
// Bundle of the pipeline chain's entry, control and observation signals.
// Latency: none, wires only; the chain itself registers every stage.
// Backpressure: in_ready plus per-stage stall_req, there is no output-side ready.
interface pipe_stage_chain_if #(
    parameter int WIDTH   = 32,
    parameter int STAGES  = 4,
    parameter int COUNT_W = 16
);
    localparam int IDX_W = $clog2(STAGES);

    // fetch-side entry
    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      in_ready;

    // per-stage hold requests and flush control
    logic [STAGES-1:0]         stall_req;
    logic                      flush;
    logic [IDX_W-1:0]          flush_stage;

    // stage observation and retire side
    logic [STAGES-1:0]         stage_valid;
    logic [STAGES*WIDTH-1:0]   stage_data;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [COUNT_W-1:0]        stall_cnt;

    // driver side: whoever feeds instructions and issues stalls/flushes
    modport master (
        output in_valid, in_data, stall_req, flush, flush_stage,
        input  in_ready, stage_valid, stage_data, out_valid, out_data, stall_cnt
    );

    // the pipeline chain itself
    modport slave (
        input  in_valid, in_data, stall_req, flush, flush_stage,
        output in_ready, stage_valid, stage_data, out_valid, out_data, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// In-order pipeline register chain (D/E/M/W style) with per-stage stall, partial flush and stall counter.
// Latency: STAGES-1 edges from acceptance into stage 0 to the last stage when nothing stalls.
// Backpressure: a stall at stage k freezes stages 0..k; in_ready drops whenever stage 0 is frozen.
module pipe_stage_chain #(
    parameter int               WIDTH       = 32,
    parameter int               STAGES      = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    pipe_stage_chain_if.slave  pipe
);
    // STAGES is expected in 2..8; a single stage would have no upstream neighbour.
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_d;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] flush_mask;
    int                flush_last;

    // A stall at stage j also freezes every younger stage, so stage k is held
    // when any request at k or above is set.
    always_comb begin
        hold = '0;
        for (int k = 0; k < STAGES; k++) begin
            hold[k] = |(pipe.stall_req >> k);
        end
    end

    // Flush clears stages 0..flush_stage; an out-of-range index means the whole chain.
    always_comb begin
        flush_last = int'(pipe.flush_stage);
        if (flush_last >= STAGES) begin
            flush_last = STAGES - 1;
        end
        flush_mask = '0;
        for (int k = 0; k < STAGES; k++) begin
            flush_mask[k] = pipe.flush && (k <= flush_last);
        end
    end

    // ------------------------------------------------------------------
    // Next-state per stage
    // ------------------------------------------------------------------
    // Stage 0 takes the fetch-side entry when not held; payload only moves on a real accept.
    always_comb begin
        valid_d[0] = valid_q[0];
        data_d[0]  = data_q[0];
        if (!hold[0]) begin
            valid_d[0] = pipe.in_valid;
            if (pipe.in_valid) begin
                data_d[0] = pipe.in_data;
            end
        end
        if (flush_mask[0]) begin
            valid_d[0] = 1'b0;
        end
    end

    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        // Older stages advance from their neighbour, or take a bubble when that neighbour is frozen.
        always_comb begin
            valid_d[g] = valid_q[g];
            data_d[g]  = data_q[g];
            if (!hold[g]) begin
                if (hold[g-1]) begin
                    valid_d[g] = 1'b0;
                end else begin
                    valid_d[g] = valid_q[g-1];
                    data_d[g]  = data_q[g-1];
                end
            end
            if (flush_mask[g]) begin
                valid_d[g] = 1'b0;
            end
        end
    end

    // Count every edge where stage 0 refuses entry, sticking at the top value.
    always_comb begin
        cnt_d = cnt_q;
        if (hold[0] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // All pipeline state; reset discards in-flight entries immediately.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= RESET_VALUE;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Flatten the payload array onto the stage_data bus, stage k at [k*WIDTH +: WIDTH].
    always_comb begin
        pipe.stage_data = '0;
        for (int k = 0; k < STAGES; k++) begin
            pipe.stage_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign pipe.in_ready    = ~hold[0];
    assign pipe.stage_valid = valid_q;
    assign pipe.out_valid   = valid_q[STAGES-1];
    assign pipe.out_data    = data_q[STAGES-1];
    assign pipe.stall_cnt   = cnt_q;

endmodule
